// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 active-low matrix keypad scanner with frame-based debounce.
// Optional auto-repeat of a held key is enabled by defining KEYPAD_REPEAT_EN.
module keypad_scanner #(
  parameter int unsigned SCAN_DIV     = 100000,
  parameter int unsigned DEBOUNCE_CNT = 4,
  parameter int unsigned REPEAT_DELAY = 50,
  parameter int unsigned REPEAT_RATE  = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key,
  output logic       key_valid,
  output logic       key_down
);

  localparam int unsigned      DIV_W        = $clog2(SCAN_DIV) + 1;
  localparam int unsigned      DB_W         = $clog2(DEBOUNCE_CNT) + 1;
  localparam logic [DIV_W-1:0] DIV_LAST     = DIV_W'(SCAN_DIV - 1);
  localparam logic [DB_W-1:0]  DB_TARGET    = DB_W'(DEBOUNCE_CNT);
  localparam bit               DB_IMMEDIATE = (DEBOUNCE_CNT <= 1);

  // Elaboration-time parameter sanity checks
  if (SCAN_DIV < 4) begin : g_chk_scan_div
    $error("keypad_scanner: SCAN_DIV must be at least 4");
  end
  if (DEBOUNCE_CNT < 1) begin : g_chk_debounce
    $error("keypad_scanner: DEBOUNCE_CNT must be at least 1");
  end
  if ((REPEAT_DELAY < 1) || (REPEAT_RATE < 1)) begin : g_chk_repeat
    $error("keypad_scanner: REPEAT_DELAY and REPEAT_RATE must be at least 1");
  end

  typedef enum logic [1:0] {IDLE, CONFIRM, PRESSED, RELEASE} state_t;

  logic [3:0]       row_meta;
  logic [3:0]       row_sync;
  logic [DIV_W-1:0] div_cnt;
  logic [1:0]       col_idx;
  logic [1:0]       col_idx_nxt;
  logic             acc_hit;
  logic [3:0]       acc_code;
  logic             sample;
  logic             frame_end;
  logic             col_hit;
  logic [3:0]       col_code;
  logic             merged_hit;
  logic [3:0]       merged_code;
  state_t           state;
  logic [3:0]       cand;
  logic [DB_W-1:0]  cnt;
  logic [DB_W-1:0]  cnt_inc;

`ifdef KEYPAD_REPEAT_EN
  localparam int unsigned      RPT_MAX   = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned      RPT_W     = $clog2(RPT_MAX) + 1;
  localparam logic [RPT_W-1:0] RPT_DELAY = RPT_W'(REPEAT_DELAY);
  localparam logic [RPT_W-1:0] RPT_RATE  = RPT_W'(REPEAT_RATE);

  logic [RPT_W-1:0] rep_cnt;
  logic [RPT_W-1:0] rep_inc;
  logic [RPT_W-1:0] rep_target;
  logic             rep_first;

  assign rep_inc    = rep_cnt + RPT_W'(1);
  assign rep_target = rep_first ? RPT_DELAY : RPT_RATE;
`endif

  assign col_idx_nxt = col_idx + 2'd1;
  assign cnt_inc     = cnt + DB_W'(1);

  // Two-flop synchroniser; idle rows read as all-high
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_meta <= 4'hF;
      row_sync <= 4'hF;
    end else begin
      row_meta <= row;
      row_sync <= row_meta;
    end
  end

  // Column code and running frame minimum; row index dominates the code
  always_comb begin
    sample    = (div_cnt == DIV_LAST);
    frame_end = sample && (col_idx == 2'd3);
    col_hit   = ~&row_sync;
    col_code  = {2'd3, col_idx};
    for (int r = 3; r >= 0; r--) begin
      if (!row_sync[r]) col_code = {2'(r), col_idx};
    end
    merged_hit  = acc_hit;
    merged_code = acc_code;
    if (col_hit && (!acc_hit || (col_code < acc_code))) begin
      merged_hit  = 1'b1;
      merged_code = col_code;
    end
  end

  // Column dwell counter, column drive and per-frame accumulator
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt  <= '0;
      col_idx  <= '0;
      col      <= 4'b1110;
      acc_hit  <= 1'b0;
      acc_code <= '0;
    end else if (sample) begin
      div_cnt <= '0;
      col_idx <= col_idx_nxt;
      col     <= ~(4'b0001 << col_idx_nxt);
      if (frame_end) begin
        acc_hit  <= 1'b0;
        acc_code <= '0;
      end else begin
        acc_hit  <= merged_hit;
        acc_code <= merged_code;
      end
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // Debounce FSM, advanced only at frame end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cand      <= '0;
      cnt       <= '0;
      key       <= '0;
      key_valid <= 1'b0;
      key_down  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt   <= '0;
      rep_first <= 1'b0;
`endif
    end else begin
      key_valid <= 1'b0;
      if (frame_end) begin
        unique case (state)
          IDLE: begin
            if (merged_hit) begin
              if (DB_IMMEDIATE) begin
                state     <= PRESSED;
                key       <= merged_code;
                key_valid <= 1'b1;
                key_down  <= 1'b1;
                cnt       <= '0;
`ifdef KEYPAD_REPEAT_EN
                rep_cnt   <= '0;
                rep_first <= 1'b1;
`endif
              end else begin
                state <= CONFIRM;
                cand  <= merged_code;
                cnt   <= DB_W'(1);
              end
            end
          end
          CONFIRM: begin
            if (!merged_hit) begin
              state <= IDLE;
              cnt   <= '0;
            end else if (merged_code == cand) begin
              if (cnt_inc >= DB_TARGET) begin
                state     <= PRESSED;
                key       <= cand;
                key_valid <= 1'b1;
                key_down  <= 1'b1;
                cnt       <= '0;
`ifdef KEYPAD_REPEAT_EN
                rep_cnt   <= '0;
                rep_first <= 1'b1;
`endif
              end else begin
                cnt <= cnt_inc;
              end
            end else begin
              cand <= merged_code;
              cnt  <= DB_W'(1);
            end
          end
          PRESSED: begin
            if (merged_hit && (merged_code == key)) begin
`ifdef KEYPAD_REPEAT_EN
              if (rep_inc >= rep_target) begin
                key_valid <= 1'b1;
                rep_cnt   <= '0;
                rep_first <= 1'b0;
              end else begin
                rep_cnt <= rep_inc;
              end
`endif
            end else if (DB_IMMEDIATE) begin
              state    <= IDLE;
              key_down <= 1'b0;
              cnt      <= '0;
`ifdef KEYPAD_REPEAT_EN
              rep_cnt   <= '0;
              rep_first <= 1'b0;
`endif
            end else begin
              state <= RELEASE;
              cnt   <= DB_W'(1);
            end
          end
          RELEASE: begin
            // Returning to the held key resumes without a new strobe
            if (merged_hit && (merged_code == key)) begin
              state <= PRESSED;
              cnt   <= '0;
            end else if (cnt_inc >= DB_TARGET) begin
              state    <= IDLE;
              key_down <= 1'b0;
              cnt      <= '0;
`ifdef KEYPAD_REPEAT_EN
              rep_cnt   <= '0;
              rep_first <= 1'b0;
`endif
            end else begin
              cnt <= cnt_inc;
            end
          end
        endcase
      end
    end
  end

endmodule
